// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver for the serial command link.
// Samples each bit three times around its centre and takes the majority.
// Rejects false starts and flags parity and frame errors. Each received
// word is held in a one-entry register with a valid/ack handshake and
// overrun detection.

`ifndef BAUD24M
// Divisor for 115200 baud from a 24 MHz clock.
`define BAUD24M 208
`endif

module uart_rx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int BAUD_RATE = `BAUD24M
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 rx_done,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int H     = BAUD_RATE / 2;
  localparam int CNT_W = $clog2(BAUD_RATE);
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_reg, state_next;

  // line_reg[1] is the synchronised line and line_reg[2] is the edge-detect copy.
  // fill_reg tracks which stages hold a real pin sample rather than a reset
  // value. Without it, a line already low at reset release would look like a
  // falling edge.
  logic [2:0]           line_reg;
  logic [2:0]           fill_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic                 s0_reg, s1_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit_reg;
  logic                 ferr_reg;

  logic rx_sync;
  logic start_edge;
  logic at_s0, at_s1, at_dec, at_wrap;
  logic maj;
  logic last_data, last_stop;
  logic commit;
  logic xor_all;
  logic par_err;

  assign rx_sync    = line_reg[1];
  assign start_edge = fill_reg[2] && line_reg[2] && !line_reg[1];

  assign at_s0   = (cnt_reg == CNT_W'(H - 1));
  assign at_s1   = (cnt_reg == CNT_W'(H));
  assign at_dec  = (cnt_reg == CNT_W'(H + 1));
  assign at_wrap = (cnt_reg == CNT_W'(BAUD_RATE - 1));

  // The third sample is the live synced line on the decision cycle.
  assign maj = (s0_reg & s1_reg) | (s0_reg & rx_sync) | (s1_reg & rx_sync);

  assign last_data = (bit_idx_reg == IDX_W'(DATA_BITS - 1));
  assign last_stop = (bit_idx_reg == IDX_W'(STOP_BITS - 1));

  assign xor_all = (^shift_reg) ^ par_bit_reg;
  assign par_err = (PARITY == 1) ? xor_all :
                   (PARITY == 2) ? !xor_all : 1'b0;

  // Two-flop synchroniser followed by the edge-detect register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_reg <= 3'b111;
      fill_reg <= 3'b000;
    end else begin
      line_reg <= {line_reg[1:0], rx};
      fill_reg <= {fill_reg[1:0], 1'b1};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic: bits advance on timer wrap.
  // A false start and the final stop bit both leave at the decision point.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start_edge) state_next = S_START;
      S_START: begin
        if (at_dec && maj)  state_next = S_IDLE;
        else if (at_wrap)   state_next = S_DATA;
      end
      S_DATA:   if (at_wrap && last_data) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (at_wrap) state_next = S_STOP;
      S_STOP:   if (at_dec && last_stop) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the commit strobe at the last stop-bit decision.
  always_comb begin
    busy   = (state_reg != S_IDLE);
    commit = (state_reg == S_STOP) && at_dec && last_stop;
  end

  // Bit timer, sample capture, shift register and per-frame error tracking.
  // The timer is already at 1 on the first START cycle, so cnt lines up with
  // the position of the synced line inside the bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      s0_reg      <= 1'b1;
      s1_reg      <= 1'b1;
      shift_reg   <= '0;
      par_bit_reg <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      if (state_reg == S_IDLE)
        cnt_reg <= start_edge ? CNT_W'(1) : '0;
      else if (at_wrap)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + 1'b1;

      if (state_reg != state_next) bit_idx_reg <= '0;
      else if (at_wrap)            bit_idx_reg <= bit_idx_reg + 1'b1;

      if (at_s0) s0_reg <= rx_sync;
      if (at_s1) s1_reg <= rx_sync;

      if (state_reg == S_DATA && at_dec)
        shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};

      if (state_reg == S_PARITY && at_dec)
        par_bit_reg <= maj;

      if (state_reg == S_START)
        ferr_reg <= 1'b0;
      else if (state_reg == S_STOP && at_dec && !maj)
        ferr_reg <= 1'b1;
    end
  end

  // Holding register, handshake and overrun tracking.
  // An ack on the commit cycle retires the old word, so no overrun is flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_received <= '0;
      rx_done       <= 1'b0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      rx_done <= commit;
      if (commit) begin
        data_received <= shift_reg;
        parity_error  <= par_err;
        frame_error   <= ferr_reg | !maj;
      end

      if (commit)        data_valid <= 1'b1;
      else if (data_ack) data_valid <= 1'b0;

      if (commit && data_valid && !data_ack) overrun_error <= 1'b1;
      else if (data_ack && data_valid)       overrun_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for two receiver configurations.
// Instance a is 8 data bits, even parity and 1 stop bit.
// Instance b is 7 data bits, odd parity and 2 stop bits.
// Both instances use 16 clocks per bit.

module tb_uart_rx_cfg;

  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rx_a, rx_b, ack_a, ack_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       done_a, valid_a, pe_a, fe_a, ovr_a, busy_a;
  logic       done_b, valid_b, pe_b, fe_b, ovr_b, busy_b;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BAUD_RATE(BAUD)) u_dut_a (
    .clk(clk), .reset(rst_a), .rx(rx_a), .data_ack(ack_a),
    .data_received(data_a), .rx_done(done_a), .data_valid(valid_a),
    .parity_error(pe_a), .frame_error(fe_a), .overrun_error(ovr_a), .busy(busy_a)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .BAUD_RATE(BAUD)) u_dut_b (
    .clk(clk), .reset(rst_b), .rx(rx_b), .data_ack(ack_b),
    .data_received(data_b), .rx_done(done_b), .data_valid(valid_b),
    .parity_error(pe_b), .frame_error(fe_b), .overrun_error(ovr_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       ovr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   cnt_done_a = 0;
  int   cnt_done_b = 0;

  // Scoreboard for instance a.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      cnt_done_a++;
      $display("rx a: data=0x%0h pe=%0b fe=%0b ovr=%0b", data_a, pe_a, fe_a, ovr_a);
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        ea = q_a.pop_front();
        check("a_data", {24'd0, data_a}, {23'd0, ea.data});
        check("a_parity_error", {31'd0, pe_a}, {31'd0, ea.pe});
        check("a_frame_error", {31'd0, fe_a}, {31'd0, ea.fe});
        check("a_overrun", {31'd0, ovr_a}, {31'd0, ea.ovr});
        check("a_valid_on_done", {31'd0, valid_a}, 1);
      end
    end
  end

  // Scoreboard for instance b.
  always @(negedge clk) begin
    if (done_b === 1'b1) begin
      cnt_done_b++;
      $display("rx b: data=0x%0h pe=%0b fe=%0b ovr=%0b", data_b, pe_b, fe_b, ovr_b);
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        eb = q_b.pop_front();
        check("b_data", {25'd0, data_b}, {23'd0, eb.data});
        check("b_parity_error", {31'd0, pe_b}, {31'd0, eb.pe});
        check("b_frame_error", {31'd0, fe_b}, {31'd0, eb.fe});
        check("b_overrun", {31'd0, ovr_b}, {31'd0, eb.ovr});
        check("b_valid_on_done", {31'd0, valid_b}, 1);
      end
    end
  end

  // Drive one frame and push its expected result.
  // glitch_bit inverts one cycle at the centre of that frame bit.
  // ack_at_commit pulses data_ack so it is sampled on the commit edge.
  // abort_at >= 0 stops driving after that many cycles and pushes nothing.
  task automatic send(input bit to_b, input logic [8:0] data, input bit bad_par,
                      input bit bad_stop, input int glitch_bit, input bit ack_at_commit,
                      input int abort_at, input bit exp_ovr);
    logic bits [16];
    int   nd, ns, n, commit_j;
    logic p, v;
    exp_t e;
    nd = to_b ? 7 : 8;
    ns = to_b ? 2 : 1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) bits[1 + i] = data[i];
    n = 1 + nd;
    p = ^data;
    if (to_b) p = ~p;
    if (bad_par) p = ~p;
    bits[n] = p;
    n++;
    for (int s = 0; s < ns; s++) begin
      bits[n] = bad_stop ? 1'b0 : 1'b1;
      n++;
    end
    // Fall at edge 1, synced at edge 2, START at edge 3 with cnt = 1.
    // The last-bit decision is at cnt = HALF+1, so the commit edge is
    // BAUD*(n-1) + HALF + 4, and data_ack is driven one cycle before it.
    commit_j = BAUD * (n - 1) + HALF + 3;
    if (abort_at < 0) begin
      e.data = data;
      e.pe   = bad_par;
      e.fe   = bad_stop;
      e.ovr  = exp_ovr;
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
    @(posedge clk);
    for (int j = 0; j < n * BAUD; j++) begin
      if (abort_at >= 0 && j == abort_at) break;
      v = bits[j / BAUD];
      if ((j / BAUD) == glitch_bit && (j % BAUD) == HALF) v = ~v;
      if (to_b) rx_b = v;
      else      rx_a = v;
      ack_a = ack_at_commit && (j == commit_j);
      @(posedge clk);
    end
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    ack_a = 1'b0;
  endtask

  // Acknowledge the held word and check that valid and overrun clear.
  task automatic ack_word(input bit to_b, input string tag);
    @(posedge clk);
    if (to_b) ack_b = 1'b1;
    else      ack_a = 1'b1;
    @(posedge clk);
    ack_a = 1'b0;
    ack_b = 1'b0;
    @(negedge clk);
    check({tag, "_valid_clr"}, {31'd0, to_b ? valid_b : valid_a}, 0);
    check({tag, "_ovr_clr"}, {31'd0, to_b ? ovr_b : ovr_a}, 0);
  endtask

  int saw_busy, busy_len, done_snap;

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; ack_a = 1'b0; ack_b = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_data", {24'd0, data_a}, 0);
    check("rst_a_done", {31'd0, done_a}, 0);
    check("rst_a_valid", {31'd0, valid_a}, 0);
    check("rst_a_flags", {29'd0, pe_a, fe_a, ovr_a}, 0);
    check("rst_a_busy", {31'd0, busy_a}, 0);
    check("rst_b_outs", {25'd0, data_b} | {26'd0, done_b, valid_b, pe_b, fe_b, ovr_b, busy_b}, 0);
    @(posedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (5) @(posedge clk);

    // Clean frame with correct even parity.
    send(0, 9'h0B3, 0, 0, -1, 0, -1, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t1_valid_held", {31'd0, valid_a}, 1);
    ack_word(0, "t1");

    // Parity error, then a clean frame clears the flag.
    send(0, 9'h012, 1, 0, -1, 0, -1, 0);
    @(negedge clk);
    check("t2_pe_set", {31'd0, pe_a}, 1);
    ack_word(0, "t2a");
    send(0, 9'h0B3, 0, 0, -1, 0, -1, 0);
    @(negedge clk);
    check("t2_pe_cleared", {31'd0, pe_a}, 0);
    ack_word(0, "t2b");

    // Frame error, one idle bit, then a clean frame.
    send(0, 9'h0A5, 0, 1, -1, 0, -1, 0);
    @(negedge clk);
    check("t3_fe_set", {31'd0, fe_a}, 1);
    ack_word(0, "t3a");
    repeat (BAUD) @(posedge clk);
    send(0, 9'h05A, 0, 0, -1, 0, -1, 0);
    @(negedge clk);
    check("t3_fe_cleared", {31'd0, fe_a}, 0);

    // Three-cycle glitch in IDLE with a word still held.
    done_snap = cnt_done_a;
    @(posedge clk);
    rx_a = 1'b0;
    repeat (3) @(posedge clk);
    rx_a = 1'b1;
    saw_busy = 0;
    busy_len = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy_a) begin
        saw_busy = 1;
        busy_len++;
      end
    end
    check("t4_busy_pulsed", saw_busy, 1);
    check("t4_busy_len_ok", {31'd0, (busy_len >= 1 && busy_len <= HALF + 2)}, 1);
    check("t4_busy_idle", {31'd0, busy_a}, 0);
    check("t4_no_done", cnt_done_a, done_snap);
    check("t4_valid_kept", {31'd0, valid_a}, 1);
    check("t4_data_kept", {24'd0, data_a}, 32'h5A);
    ack_word(0, "t4a");
    // A one-cycle glitch at the centre of data bit 2 is outvoted.
    send(0, 9'h06C, 0, 0, 3, 0, -1, 0);
    ack_word(0, "t4b");

    // Back-to-back frames without an ack overrun.
    send(0, 9'h011, 0, 0, -1, 0, -1, 0);
    send(0, 9'h022, 0, 0, -1, 0, -1, 1);
    @(negedge clk);
    check("t5_ovr_set", {31'd0, ovr_a}, 1);
    check("t5_data_new", {24'd0, data_a}, 32'h22);
    ack_word(0, "t5a");
    // An ack on the commit edge retires the old word without an overrun.
    send(0, 9'h033, 0, 0, -1, 0, -1, 0);
    send(0, 9'h044, 0, 0, -1, 1, -1, 0);
    @(negedge clk);
    check("t5_simul_valid", {31'd0, valid_a}, 1);
    check("t5_simul_ovr", {31'd0, ovr_a}, 0);
    ack_word(0, "t5b");

    // Instance b: 7 data bits, odd parity, 2 stop bits.
    send(1, 9'h012, 0, 0, -1, 0, -1, 0);
    ack_word(1, "t6a");
    done_snap = cnt_done_b;
    send(1, 9'h055, 0, 0, -1, 0, BAUD * 5 + 3, 0);
    #2;
    check("t6_busy_mid", {31'd0, busy_b}, 1);
    rst_b = 1'b1;
    #2;
    check("t6_rst_data", {25'd0, data_b}, 0);
    check("t6_rst_outs", {26'd0, done_b, valid_b, pe_b, fe_b, ovr_b, busy_b}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    repeat (10) @(posedge clk);
    check("t6_no_done", cnt_done_b, done_snap);
    send(1, 9'h03C, 0, 0, -1, 0, -1, 0);
    ack_word(1, "t6b");

    repeat (5) @(posedge clk);
    check("end_qa_empty", q_a.size(), 0);
    check("end_qb_empty", q_b.size(), 0);
    check("end_done_a", cnt_done_a, 10);
    check("end_done_b", cnt_done_b, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
